satagtx_clk_seq: RTL and testbench

- Parametrised multi-tile clock/reset sequencer for the SATA GTX/GTP clocking path.
- Per tile, it watches the transceiver PLL lock-detect and the user-clock DCM/PLL lock.
- It sequences the user-clock source reset, then the transceiver datapath reset, and flags the tile ready.
- On lock loss, timeout or soft reset it recovers automatically. It sits between the transceiver tiles / user-clock sources and the SATA link layer.

---
 rtl/satagtx_clk_seq_if.sv | 45 ++++
 rtl/satagtx_clk_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_satagtx_clk_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/satagtx_clk_seq_if.sv
// -----------------------------------------------------------------------------
// satagtx_clk_seq_if
// Groups the per-tile lock, restart and reset/ready signals exchanged between
// the clock/reset sequencer and its surroundings (transceiver tiles, user-clock
// sources and the SATA link layer).
//
// Signals (C_NUM_TILES bits unless noted):
//   pll_lkdet      transceiver PLL lock per tile (asynchronous to clk)
//   usrclk_locked  user-clock DCM/PLL lock per tile (asynchronous to clk)
//   soft_rst       synchronous per-tile restart request, level
//   usrclk_reset   reset to each tile's user-clock DCM/PLL
//   gtx_reset      transceiver datapath reset per tile
//   tile_ready     tile clocks stable and resets released
//   all_ready      1 bit, AND of tile_ready (one cycle later)
//   retry_cnt      C_NUM_TILES*C_RETRY_W bits, tile i at [i*C_RETRY_W +: C_RETRY_W]
//
// Modports:
//   master  environment side: drives locks and restart, observes resets/ready
//   slave   sequencer side
// -----------------------------------------------------------------------------
interface satagtx_clk_seq_if #(
  parameter int C_NUM_TILES = 1,
  parameter int C_RETRY_W   = 4
) ();

  logic [C_NUM_TILES-1:0]           pll_lkdet;
  logic [C_NUM_TILES-1:0]           usrclk_locked;
  logic [C_NUM_TILES-1:0]           soft_rst;
  logic [C_NUM_TILES-1:0]           usrclk_reset;
  logic [C_NUM_TILES-1:0]           gtx_reset;
  logic [C_NUM_TILES-1:0]           tile_ready;
  logic                             all_ready;
  logic [C_NUM_TILES*C_RETRY_W-1:0] retry_cnt;

  modport master (
    output pll_lkdet, usrclk_locked, soft_rst,
    input  usrclk_reset, gtx_reset, tile_ready, all_ready, retry_cnt
  );

  modport slave (
    input  pll_lkdet, usrclk_locked, soft_rst,
    output usrclk_reset, gtx_reset, tile_ready, all_ready, retry_cnt
  );

endinterface

// File: rtl/satagtx_clk_seq.sv
// -----------------------------------------------------------------------------
// satagtx_clk_seq
// Multi-tile clock/reset sequencer for the SATA GTX/GTP clocking path. Each
// tile waits for a filtered transceiver PLL lock, pulses the user-clock source
// reset, waits for a filtered user-clock lock (retrying on timeout), pulses the
// transceiver datapath reset and then flags the tile ready. Lock loss or a soft
// restart returns the tile to the appropriate earlier step automatically.
//
// Ports:
//   clk  free-running system clock, rising edge
//   rst  asynchronous active-high reset
//   sif  satagtx_clk_seq_if.slave (lock inputs, soft_rst, resets, ready, retry_cnt)
// -----------------------------------------------------------------------------
module satagtx_clk_seq #(
  parameter int C_NUM_TILES   = 1,
  parameter int C_LOCK_FILTER = 16,
  parameter int C_RST_HOLD    = 8,
  parameter int C_TIMEOUT     = 1024,
  parameter int C_RETRY_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  satagtx_clk_seq_if.slave sif
);

  // One counter width serves the lock filter, the reset hold and the timeout.
  localparam int CNT_MAX_FH = (C_LOCK_FILTER > C_RST_HOLD) ? C_LOCK_FILTER : C_RST_HOLD;
  localparam int CNT_MAX    = (C_TIMEOUT > CNT_MAX_FH) ? C_TIMEOUT : CNT_MAX_FH;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  // Terminal values: the transition fires on the edge that completes the count.
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(C_LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(C_RST_HOLD - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(C_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    PLL_WAIT = 3'd0,
    DCM_RST  = 3'd1,
    DCM_WAIT = 3'd2,
    GTX_RST  = 3'd3,
    READY    = 3'd4
  } state_t;

  // Saturating increment for the retry counters.
  function automatic logic [C_RETRY_W-1:0] sat_inc(input logic [C_RETRY_W-1:0] val);
    logic [C_RETRY_W-1:0] res;
    if (val == {C_RETRY_W{1'b1}}) begin
      res = val;
    end else begin
      res = val + {{(C_RETRY_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  logic [C_NUM_TILES-1:0]           pll_meta_r;
  logic [C_NUM_TILES-1:0]           pll_sync_r;
  logic [C_NUM_TILES-1:0]           lock_meta_r;
  logic [C_NUM_TILES-1:0]           lock_sync_r;
  logic [C_NUM_TILES-1:0]           usrclk_reset_s;
  logic [C_NUM_TILES-1:0]           gtx_reset_s;
  logic [C_NUM_TILES-1:0]           tile_ready_s;
  logic [C_NUM_TILES*C_RETRY_W-1:0] retry_cnt_s;
  logic                             all_ready_r;

  // Two-flop synchronizers for the asynchronous lock indications.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pll_meta_r  <= {C_NUM_TILES{1'b0}};
      pll_sync_r  <= {C_NUM_TILES{1'b0}};
      lock_meta_r <= {C_NUM_TILES{1'b0}};
      lock_sync_r <= {C_NUM_TILES{1'b0}};
    end else begin
      pll_meta_r  <= sif.pll_lkdet;
      pll_sync_r  <= pll_meta_r;
      lock_meta_r <= sif.usrclk_locked;
      lock_sync_r <= lock_meta_r;
    end
  end

  for (genvar g = 0; g < C_NUM_TILES; g++) begin : g_tile
    state_t               state_r;
    state_t               state_nxt_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_nxt_s;
    logic [CNT_W-1:0]     tmo_r;
    logic [CNT_W-1:0]     tmo_nxt_s;
    logic [C_RETRY_W-1:0] retry_r;
    logic [C_RETRY_W-1:0] retry_nxt_s;
    logic                 usrclk_reset_r;
    logic                 gtx_reset_r;
    logic                 tile_ready_r;
    logic                 usrclk_reset_nxt_s;
    logic                 gtx_reset_nxt_s;
    logic                 tile_ready_nxt_s;
    logic                 pll_s;
    logic                 lock_s;
    logic                 srst_s;

    assign pll_s  = pll_sync_r[g];
    assign lock_s = lock_sync_r[g];
    assign srst_s = sif.soft_rst[g];

    // Next-state and counter logic; soft restart, then PLL loss, then
    // user-clock loss / timeout, then normal progression.
    always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      tmo_nxt_s   = tmo_r;
      retry_nxt_s = retry_r;
      if (srst_s) begin
        state_nxt_s = PLL_WAIT;
        cnt_nxt_s   = CNT_ZERO;
        tmo_nxt_s   = CNT_ZERO;
        retry_nxt_s = {C_RETRY_W{1'b0}};
      end else if ((state_r != PLL_WAIT) && !pll_s) begin
        state_nxt_s = PLL_WAIT;
        cnt_nxt_s   = CNT_ZERO;
        tmo_nxt_s   = CNT_ZERO;
      end else begin
        case (state_r)
          PLL_WAIT: begin
            if (!pll_s) begin
              cnt_nxt_s = CNT_ZERO;
            end else if (cnt_r == FILT_LAST) begin
              state_nxt_s = DCM_RST;
              cnt_nxt_s   = CNT_ZERO;
            end else begin
              cnt_nxt_s = cnt_r + CNT_ONE;
            end
          end
          DCM_RST: begin
            if (cnt_r == HOLD_LAST) begin
              state_nxt_s = DCM_WAIT;
              cnt_nxt_s   = CNT_ZERO;
              tmo_nxt_s   = CNT_ZERO;
            end else begin
              cnt_nxt_s = cnt_r + CNT_ONE;
            end
          end
          DCM_WAIT: begin
            // Timeout counts from state entry regardless of lock glitches;
            // the filter restarts on every low sample.
            if (tmo_r == TMO_LAST) begin
              state_nxt_s = DCM_RST;
              cnt_nxt_s   = CNT_ZERO;
              tmo_nxt_s   = CNT_ZERO;
              retry_nxt_s = sat_inc(retry_r);
            end else if (!lock_s) begin
              cnt_nxt_s = CNT_ZERO;
              tmo_nxt_s = tmo_r + CNT_ONE;
            end else if (cnt_r == FILT_LAST) begin
              state_nxt_s = GTX_RST;
              cnt_nxt_s   = CNT_ZERO;
              tmo_nxt_s   = CNT_ZERO;
            end else begin
              cnt_nxt_s = cnt_r + CNT_ONE;
              tmo_nxt_s = tmo_r + CNT_ONE;
            end
          end
          GTX_RST: begin
            if (cnt_r == HOLD_LAST) begin
              state_nxt_s = READY;
              cnt_nxt_s   = CNT_ZERO;
            end else begin
              cnt_nxt_s = cnt_r + CNT_ONE;
            end
          end
          READY: begin
            if (!lock_s) begin
              state_nxt_s = DCM_RST;
              cnt_nxt_s   = CNT_ZERO;
            end else begin
              state_nxt_s = READY;
            end
          end
          default: begin
            state_nxt_s = PLL_WAIT;
            cnt_nxt_s   = CNT_ZERO;
            tmo_nxt_s   = CNT_ZERO;
          end
        endcase
      end
    end

    // Output decode from the next state so the registered outputs track the state.
    always_comb begin
      usrclk_reset_nxt_s = 1'b1;
      gtx_reset_nxt_s    = 1'b1;
      tile_ready_nxt_s   = 1'b0;
      case (state_nxt_s)
        PLL_WAIT, DCM_RST: begin
          usrclk_reset_nxt_s = 1'b1;
          gtx_reset_nxt_s    = 1'b1;
          tile_ready_nxt_s   = 1'b0;
        end
        DCM_WAIT, GTX_RST: begin
          usrclk_reset_nxt_s = 1'b0;
          gtx_reset_nxt_s    = 1'b1;
          tile_ready_nxt_s   = 1'b0;
        end
        READY: begin
          usrclk_reset_nxt_s = 1'b0;
          gtx_reset_nxt_s    = 1'b0;
          tile_ready_nxt_s   = 1'b1;
        end
        default: begin
          usrclk_reset_nxt_s = 1'b1;
          gtx_reset_nxt_s    = 1'b1;
          tile_ready_nxt_s   = 1'b0;
        end
      endcase
    end

    // State, counters and registered outputs of this tile.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_r        <= PLL_WAIT;
        cnt_r          <= CNT_ZERO;
        tmo_r          <= CNT_ZERO;
        retry_r        <= {C_RETRY_W{1'b0}};
        usrclk_reset_r <= 1'b1;
        gtx_reset_r    <= 1'b1;
        tile_ready_r   <= 1'b0;
      end else begin
        state_r        <= state_nxt_s;
        cnt_r          <= cnt_nxt_s;
        tmo_r          <= tmo_nxt_s;
        retry_r        <= retry_nxt_s;
        usrclk_reset_r <= usrclk_reset_nxt_s;
        gtx_reset_r    <= gtx_reset_nxt_s;
        tile_ready_r   <= tile_ready_nxt_s;
      end
    end

    assign usrclk_reset_s[g]                        = usrclk_reset_r;
    assign gtx_reset_s[g]                           = gtx_reset_r;
    assign tile_ready_s[g]                          = tile_ready_r;
    assign retry_cnt_s[g*C_RETRY_W +: C_RETRY_W]    = retry_r;
  end

  // all_ready is a registered AND of the per-tile ready flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      all_ready_r <= 1'b0;
    end else begin
      all_ready_r <= &tile_ready_s;
    end
  end

  assign sif.usrclk_reset = usrclk_reset_s;
  assign sif.gtx_reset    = gtx_reset_s;
  assign sif.tile_ready   = tile_ready_s;
  assign sif.all_ready    = all_ready_r;
  assign sif.retry_cnt    = retry_cnt_s;

endmodule

// File: tb/tb_satagtx_clk_seq.sv
// -----------------------------------------------------------------------------
// tb_satagtx_clk_seq
// Self-checking bench for satagtx_clk_seq with two tiles and default timing.
// Cycle numbers count rising edges after rst is released; outputs are sampled
// 1 time unit after each rising edge and inputs are driven at the same point.
// -----------------------------------------------------------------------------
module tb_satagtx_clk_seq;

  typedef struct {
    int         cyc;
    logic [1:0] pll;
    logic [1:0] lock;
    logic [1:0] usr;
    logic [1:0] gtx;
    logic [1:0] rdy;
    logic       all;
    logic [7:0] retry;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] pll_lkdet;
  logic [1:0] usrclk_locked;
  logic [1:0] soft_rst;
  int         cyc;
  int         n_tests;
  int         n_fail;
  vec_t       vecs [8];

  satagtx_clk_seq_if #(.C_NUM_TILES(2), .C_RETRY_W(4)) sif ();

  assign sif.pll_lkdet     = pll_lkdet;
  assign sif.usrclk_locked = usrclk_locked;
  assign sif.soft_rst      = soft_rst;

  satagtx_clk_seq #(
    .C_NUM_TILES   (2),
    .C_LOCK_FILTER (16),
    .C_RST_HOLD    (8),
    .C_TIMEOUT     (1024),
    .C_RETRY_W     (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset(input logic [1:0] p, input logic [1:0] l);
    rst           = 1'b1;
    pll_lkdet     = p;
    usrclk_locked = l;
    soft_rst      = 2'b00;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_table();
    for (int i = 0; i < 8; i++) begin
      pll_lkdet     = vecs[i].pll;
      usrclk_locked = vecs[i].lock;
      run_to(vecs[i].cyc);
      chk($sformatf("tbl%0d_usrclk_reset", i), {30'd0, sif.usrclk_reset}, {30'd0, vecs[i].usr});
      chk($sformatf("tbl%0d_gtx_reset", i),    {30'd0, sif.gtx_reset},    {30'd0, vecs[i].gtx});
      chk($sformatf("tbl%0d_tile_ready", i),   {30'd0, sif.tile_ready},   {30'd0, vecs[i].rdy});
      chk($sformatf("tbl%0d_all_ready", i),    {31'd0, sif.all_ready},    {31'd0, vecs[i].all});
      chk($sformatf("tbl%0d_retry_cnt", i),    {24'd0, sif.retry_cnt},    {24'd0, vecs[i].retry});
    end
  endtask

  initial begin
    int   k;
    int   m;
    int   s;
    logic bad;

    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    // Nominal bring-up with both locks high: usrclk_reset falls at 26,
    // ready at 50, all_ready at 51.
    vecs[0] = '{cyc: 0,  pll: 2'b11, lock: 2'b11, usr: 2'b11, gtx: 2'b11, rdy: 2'b00, all: 1'b0, retry: 8'h00};
    vecs[1] = '{cyc: 18, pll: 2'b11, lock: 2'b11, usr: 2'b11, gtx: 2'b11, rdy: 2'b00, all: 1'b0, retry: 8'h00};
    vecs[2] = '{cyc: 25, pll: 2'b11, lock: 2'b11, usr: 2'b11, gtx: 2'b11, rdy: 2'b00, all: 1'b0, retry: 8'h00};
    vecs[3] = '{cyc: 26, pll: 2'b11, lock: 2'b11, usr: 2'b00, gtx: 2'b11, rdy: 2'b00, all: 1'b0, retry: 8'h00};
    vecs[4] = '{cyc: 42, pll: 2'b11, lock: 2'b11, usr: 2'b00, gtx: 2'b11, rdy: 2'b00, all: 1'b0, retry: 8'h00};
    vecs[5] = '{cyc: 49, pll: 2'b11, lock: 2'b11, usr: 2'b00, gtx: 2'b11, rdy: 2'b00, all: 1'b0, retry: 8'h00};
    vecs[6] = '{cyc: 50, pll: 2'b11, lock: 2'b11, usr: 2'b00, gtx: 2'b00, rdy: 2'b11, all: 1'b0, retry: 8'h00};
    vecs[7] = '{cyc: 51, pll: 2'b11, lock: 2'b11, usr: 2'b00, gtx: 2'b00, rdy: 2'b11, all: 1'b1, retry: 8'h00};

    // Reset values while rst is held.
    rst           = 1'b1;
    pll_lkdet     = 2'b11;
    usrclk_locked = 2'b11;
    soft_rst      = 2'b00;
    #12;
    chk("rst_usrclk_reset", {30'd0, sif.usrclk_reset}, 32'h3);
    chk("rst_tile_ready",   {30'd0, sif.tile_ready},   32'h0);

    do_reset(2'b11, 2'b11);
    run_table();

    // One-cycle usrclk_locked[0] drop while ready: DCM_RST three cycles later.
    run_to(60);
    k = cyc;
    usrclk_locked[0] = 1'b0;
    step();
    usrclk_locked[0] = 1'b1;
    step();
    chk("drop_usr_k2", {31'd0, sif.usrclk_reset[0]}, 32'h0);
    step();
    chk("drop_usr_k3",  {31'd0, sif.usrclk_reset[0]}, 32'h1);
    chk("drop_rdy_k3",  {31'd0, sif.tile_ready[0]},   32'h0);
    chk("drop_gtx_k3",  {31'd0, sif.gtx_reset[0]},    32'h1);
    chk("drop_rdy1_k3", {31'd0, sif.tile_ready[1]},   32'h1);
    step();
    chk("drop_all_k4",  {31'd0, sif.all_ready},       32'h0);
    run_to(k + 34);
    chk("drop_rdy_k34", {31'd0, sif.tile_ready[0]},   32'h0);
    step();
    chk("drop_rdy_k35", {31'd0, sif.tile_ready[0]},   32'h1);
    step();
    chk("drop_all_k36", {31'd0, sif.all_ready},       32'h1);
    chk("drop_retry",   {24'd0, sif.retry_cnt},       32'h0);

    // soft_rst[0] coinciding (at the FSM) with synced usrclk_locked[0] loss.
    m = cyc;
    usrclk_locked[0] = 1'b0;
    step();
    step();
    soft_rst[0]      = 1'b1;
    usrclk_locked[0] = 1'b1;
    step();
    soft_rst[0] = 1'b0;
    chk("srst_usr_m3", {31'd0, sif.usrclk_reset[0]}, 32'h1);
    chk("srst_rdy_m3", {31'd0, sif.tile_ready[0]},   32'h0);
    chk("srst_retry",  {28'd0, sif.retry_cnt[3:0]},  32'h0);
    run_to(m + 26);
    chk("srst_usr_m26", {31'd0, sif.usrclk_reset[0]}, 32'h1);
    step();
    chk("srst_usr_m27", {31'd0, sif.usrclk_reset[0]}, 32'h0);

    // pll_lkdet[0] toggling every 10 cycles never passes the 16-sample filter.
    do_reset(2'b11, 2'b11);
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      pll_lkdet[0] = (((i / 10) % 2) == 0);
      step();
      if (sif.usrclk_reset[0] !== 1'b1 || sif.tile_ready[0] !== 1'b0) bad = 1'b1;
      if (i == 59) chk("tog_rdy1_c60", {31'd0, sif.tile_ready[1]}, 32'h1);
    end
    chk("tog_stuck_pll_wait", {31'd0, bad}, 32'h0);
    k = cyc;
    pll_lkdet[0] = 1'b1;
    run_to(k + 49);
    chk("tog_rdy0_49", {31'd0, sif.tile_ready[0]}, 32'h0);
    step();
    chk("tog_rdy0_50", {31'd0, sif.tile_ready[0]}, 32'h1);
    chk("tog_rdy1_50", {31'd0, sif.tile_ready[1]}, 32'h1);

    // usrclk_locked[1] held low: DCM_RST/DCM_WAIT every 1032 cycles, retry saturates.
    do_reset(2'b11, 2'b01);
    bad = 1'b0;
    while (cyc < 16600) begin
      step();
      if (sif.gtx_reset[1] !== 1'b1) bad = 1'b1;
      if (cyc == 50)    chk("ret_rdy0_50",     {31'd0, sif.tile_ready[0]},   32'h1);
      if (cyc == 1049)  chk("ret_cnt1_1049",   {28'd0, sif.retry_cnt[7:4]},  32'h0);
      if (cyc == 1050)  chk("ret_cnt1_1050",   {28'd0, sif.retry_cnt[7:4]},  32'h1);
      if (cyc == 1050)  chk("ret_usr1_1050",   {31'd0, sif.usrclk_reset[1]}, 32'h1);
      if (cyc == 1057)  chk("ret_usr1_1057",   {31'd0, sif.usrclk_reset[1]}, 32'h1);
      if (cyc == 1058)  chk("ret_usr1_1058",   {31'd0, sif.usrclk_reset[1]}, 32'h0);
      if (cyc == 2082)  chk("ret_cnt1_2082",   {28'd0, sif.retry_cnt[7:4]},  32'h2);
      if (cyc == 15497) chk("ret_cnt1_15497",  {28'd0, sif.retry_cnt[7:4]},  32'he);
      if (cyc == 15498) chk("ret_cnt1_15498",  {28'd0, sif.retry_cnt[7:4]},  32'hf);
    end
    chk("ret_gtx1_held",  {31'd0, bad},                 32'h0);
    chk("ret_cnt1_sat",   {28'd0, sif.retry_cnt[7:4]},  32'hf);
    chk("ret_cnt0",       {28'd0, sif.retry_cnt[3:0]},  32'h0);

    // soft_rst[1] held for 30 cycles: retry cleared, tile stays in PLL_WAIT.
    usrclk_locked = 2'b11;
    soft_rst      = 2'b10;
    step();
    chk("hold_cnt1_clr", {28'd0, sif.retry_cnt[7:4]},  32'h0);
    repeat (29) step();
    chk("hold_usr1",     {31'd0, sif.usrclk_reset[1]}, 32'h1);
    chk("hold_rdy0",     {31'd0, sif.tile_ready[0]},   32'h1);
    soft_rst = 2'b00;
    s = cyc;
    run_to(s + 47);
    chk("hold_rdy1_47",  {31'd0, sif.tile_ready[1]},   32'h0);
    step();
    chk("hold_rdy1_48",  {31'd0, sif.tile_ready[1]},   32'h1);

    // Asynchronous rst pulse mid-DCM_WAIT, then the full sequence again.
    do_reset(2'b11, 2'b11);
    run_to(30);
    chk("arst_pre_usr", {30'd0, sif.usrclk_reset}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_usrclk_reset", {30'd0, sif.usrclk_reset}, 32'h3);
    chk("arst_gtx_reset",    {30'd0, sif.gtx_reset},    32'h3);
    chk("arst_tile_ready",   {30'd0, sif.tile_ready},   32'h0);
    #2;
    rst = 1'b0;
    cyc = 0;
    run_table();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
